// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the 32-bit multicycle MIPS datapath.
// Sequences one instruction at a time; every select and write enable is a
// function of the current state (plus IR op/funct for ALU op choice and the
// ALU zero flag for the branch PC qualifier). Reset forces all outputs low.
module multicycle_ctrl_fsm #(
  parameter logic [5:0] OP_GPIO_IN  = 6'h3E,
  parameter logic [5:0] OP_GPIO_OUT = 6'h3F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCen,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [2:0] ALUControl,
  output logic       Ori,
  output logic       ANDIsel,
  output logic       illegal,
  output logic [3:0] state_o
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] F_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_ALUWB = 4'd7,
    S_EXEC_I  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
    S_JAL     = 4'd12, S_JR     = 4'd13, S_GPIO_WR = 4'd14, S_ILLEGAL = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] r_aluc, i_aluc;
  logic       r_legal, pc_write, br_eq, br_ne;

  // R-type funct decode: ALU operation and legality
  always_comb begin
    r_aluc  = 3'b000;
    r_legal = 1'b1;
    case (funct)
      6'h20:   r_aluc = 3'b000;
      6'h22:   r_aluc = 3'b001;
      6'h24:   r_aluc = 3'b010;
      6'h25:   r_aluc = 3'b011;
      6'h27:   r_aluc = 3'b100;
      6'h2A:   r_aluc = 3'b101;
      6'h00:   r_aluc = 3'b110;
      6'h02:   r_aluc = 3'b111;
      default: r_legal = 1'b0;
    endcase
  end

  // I-type ALU operation; GPIO_IN falls through to add (rs is $0)
  always_comb begin
    case (op)
      OP_ANDI: i_aluc = 3'b010;
      OP_ORI:  i_aluc = 3'b011;
      OP_SLTI: i_aluc = 3'b101;
      default: i_aluc = 3'b000;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = (funct == F_JR) ? S_JR :
                                    (r_legal ? S_EXEC_R : S_ILLEGAL);
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_GPIO_IN: state_d = S_EXEC_I;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          OP_GPIO_OUT:    state_d = S_GPIO_WR;
          default:        state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset returns to FETCH and abandons any instruction
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Moore output decode, held low for the whole reset cycle
  always_comb begin
    IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;
    ALUSrcA = 1'b0; ALUSrcB = 2'b00; PCSrc = 2'b00; RegDst = 2'b00;
    MemtoReg = 2'b00; ALUControl = 3'b000; Ori = 1'b0; ANDIsel = 1'b0;
    illegal = 1'b0; pc_write = 1'b0; br_eq = 1'b0; br_ne = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH:   begin IRWrite = 1'b1; ALUSrcB = 2'b01; pc_write = 1'b1; end
        S_DECODE:  ALUSrcB = 2'b11;
        S_MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        S_MEMRD:   IorD = 1'b1;
        S_MEMWB:   begin IorD = 1'b1; MemtoReg = 2'b01; RegWrite = 1'b1; end
        S_MEMWR:   begin IorD = 1'b1; MemWrite = 1'b1; end
        S_EXEC_R:  begin ALUSrcA = 1'b1; ALUControl = r_aluc; end
        S_ALUWB:   begin RegDst = 2'b01; RegWrite = 1'b1; end
        S_EXEC_I:  begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUControl = i_aluc;
          Ori = (op == OP_GPIO_IN);
        end
        S_IWB:     begin RegWrite = 1'b1; Ori = (op == OP_GPIO_IN); end
        S_BRANCH:  begin
          ALUSrcA = 1'b1; ALUControl = 3'b001; PCSrc = 2'b01;
          br_eq = (op == OP_BEQ); br_ne = (op == OP_BNE);
        end
        S_JUMP:    begin PCSrc = 2'b10; pc_write = 1'b1; end
        S_JAL:     begin
          PCSrc = 2'b10; pc_write = 1'b1; RegDst = 2'b10;
          MemtoReg = 2'b10; RegWrite = 1'b1;
        end
        S_JR:      begin PCSrc = 2'b11; pc_write = 1'b1; end
        S_GPIO_WR: ANDIsel = 1'b1;
        S_ILLEGAL: illegal = 1'b1;
        default:   ;
      endcase
    end
    PCen = pc_write | (br_eq & zero) | (br_ne & ~zero);
  end

  assign state_o = reset ? 4'd0 : state_q;

endmodule
